i2c_config_sequencer: RTL and testbench
=======================================

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 11, meaning the number of configuration words sent per sequence (1..16).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 250, meaning the idle CLOCK cycles between transfers (1..65535).
REQ-003 The block SHALL have parameter MAX_RETRY, default 3, meaning the number of re-sends allowed per word after a NACK (0..7).
REQ-004 CLOCK  in  1  the only clock; all logic is on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to run the full sequence.
REQ-007 cfg_index  out  4  config ROM address of the current word.
REQ-008 cfg_data  in  24  ROM word: device-address byte followed by 2 payload bytes; valid one cycle after cfg_index changes.
REQ-009 xfer_start  out  1  one-cycle pulse to the I2C engine; drives its InitialiseTransfer.
REQ-010 xfer_data  out  24  word held stable from xfer_start until xfer_done.
REQ-011 xfer_done  in  1  one-cycle pulse from the engine at end of transfer (count 56 reached).
REQ-012 xfer_nack  in  1  valid only with xfer_done; 1 means any ACK slot was NACKed.
REQ-013 busy  out  1  high while a sequence is in progress.
REQ-014 done  out  1  sticky; set when all words have been ACKed.
REQ-015 error  out  1  sticky; set when retries are exhausted.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, ISSUE, WAIT, GAP, FINISH and FAIL.
REQ-017 IDLE: on start=1, go to LOAD with index=0, retry=0, done=0 and error=0; start is ignored in every other state.
REQ-018 LOAD: one cycle for ROM latency; cfg_index=index; go to ISSUE.
REQ-019 ISSUE: latch cfg_data into xfer_data, assert xfer_start for exactly this cycle, and go to WAIT.
REQ-020 WAIT: hold until xfer_done=1; no timeout; xfer_done arriving in any other state SHALL be ignored.
REQ-021 WAIT with xfer_done=1 and xfer_nack=0: clear retry; if index==NUM_WORDS-1, go to FINISH, else increment index and go to GAP.
REQ-022 WAIT with xfer_done=1 and xfer_nack=1: if retry<MAX_RETRY, increment retry and go to GAP with the same index, else go to FAIL.
REQ-023 GAP: a 16-bit counter SHALL run for exactly GAP_CYCLES cycles, then go to LOAD; the counter clears on entry.
REQ-024 Timing: the gap from the xfer_done cycle to the next xfer_start SHALL be GAP_CYCLES+3 cycles (WAIT exit, GAP, LOAD, ISSUE).
REQ-025 FINISH: set done=1 for one cycle, then go to IDLE; done stays high until the next accepted start.
REQ-026 FAIL: set error=1 and hold cfg_index at the failing word, then go to IDLE; error stays high until the next accepted start.
REQ-027 busy SHALL be 1 in LOAD, ISSUE, WAIT and GAP, and 0 in IDLE, FINISH and FAIL.
REQ-028 Index arithmetic SHALL be 4-bit and never wrap; with NUM_WORDS=16, index 15 is terminal.
REQ-029 If start and xfer_done occur together in IDLE, start SHALL win and xfer_done SHALL be dropped.

Reset
REQ-030 When RESET=1 at a rising CLOCK edge, the block SHALL go to IDLE with cfg_index=0, xfer_start=0, xfer_data=0, busy=0, done=0, error=0 and all counters=0.
REQ-031 RESET in any state, including mid-WAIT, SHALL abort the sequence without a further xfer_start; the engine is reset by the same RESET.
REQ-032 RESET SHALL take priority over start.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the 24-bit word width, the default GAP_CYCLES and the 7-bit codec device address.
REQ-034 The GAP counter SHALL be one sub-module, i2c_gap_timer, with inputs load and enable, output expired, and a 16-bit width.
REQ-035 The FSM and the index/retry registers SHALL stay in i2c_config_sequencer.

Verification
REQ-036 Use NUM_WORDS=3, GAP_CYCLES=4 and an engine model with all ACKs; pulse start -> exactly 3 xfer_start pulses with data ROM[0..2], done=1, error=0, busy=0 afterwards.
REQ-037 NACK the first attempt at index 1 -> index 1 resent once, total 4 xfer_start pulses, done=1.
REQ-038 With MAX_RETRY=3, always NACK index 0 -> 4 attempts, then error=1, done=0, cfg_index=0, and no further xfer_start.
REQ-039 Assert RESET for one cycle during WAIT of index 1 -> all outputs 0 next cycle, and a late xfer_done is ignored.
REQ-040 Pulse start again while busy, and pulse xfer_done while in GAP -> no extra transfer, and the sequence completes unchanged.
REQ-041 Measure cycles from xfer_done to the next xfer_start with GAP_CYCLES=4 -> exactly 7.

Source files
------------

// File: rtl/i2c_config_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer.
//   WORD_W             : width of one config word (device-address byte + 2 payload bytes)
//   GAP_W              : width of the inter-transfer gap counter
//   DEFAULT_GAP_CYCLES : default idle cycles between transfers
//   CODEC_ADDR         : 7-bit I2C address of the audio codec
//   state_t            : sequencer FSM states
package i2c_config_sequencer_pkg;

    localparam int WORD_W             = 24;
    localparam int GAP_W              = 16;
    localparam int DEFAULT_GAP_CYCLES = 250;

    localparam logic [6:0] CODEC_ADDR = 7'h1A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        GAP,
        FINISH,
        FAIL
    } state_t;

endpackage

// File: rtl/i2c_gap_timer.sv
// Idle-gap timer between I2C transfers.
//   CLOCK   in  : clock
//   RESET   in  : synchronous active-high reset
//   load    in  : clear the counter (asserted on the cycle before the gap starts)
//   enable  in  : count while high (the gap state)
//   expired out : high on the last cycle of the gap
import i2c_config_sequencer_pkg::*;

module i2c_gap_timer #(
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [GAP_W-1:0] LAST = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0] count;

    // count k is held during the (k+1)-th gap cycle, so the gap lasts exactly
    // GAP_CYCLES cycles when expired is taken as the exit condition
    assign expired = enable && (count == LAST);

    always_ff @(posedge CLOCK) begin
        if (RESET || load) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + GAP_W'(1);
        end
    end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a config ROM and hands each word to an I2C engine, with NACK retry.
//   CLOCK, RESET   in  : clock, synchronous active-high reset
//   start          in  : one-cycle request to run the whole sequence (IDLE only)
//   cfg_index      out : ROM address of the current word
//   cfg_data       in  : ROM word, valid one cycle after cfg_index changes
//   xfer_start     out : one-cycle pulse to the engine
//   xfer_data      out : word to send, stable from xfer_start to xfer_done
//   xfer_done      in  : end-of-transfer pulse from the engine
//   xfer_nack      in  : qualifies xfer_done; 1 = some ACK slot was NACKed
//   busy           out : sequence in progress
//   done, error    out : sticky completion / retry-exhausted flags
import i2c_config_sequencer_pkg::*;

module i2c_config_sequencer #(
    parameter int NUM_WORDS  = 11,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int MAX_RETRY  = 3
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    output logic [3:0]        cfg_index,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              xfer_start,
    output logic [WORD_W-1:0] xfer_data,
    input  logic              xfer_done,
    input  logic              xfer_nack,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_WORDS - 1);
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    state_t     state;
    logic [3:0] index;
    logic [2:0] retry;
    logic       gap_load;
    logic       gap_expired;

    // the index register is the ROM address; it is updated on WAIT exit so
    // the ROM has the whole gap to settle before LOAD/ISSUE
    assign cfg_index = index;

    // counter is cleared on the WAIT exit edge, i.e. on entry to GAP
    assign gap_load = (state == WAIT) && xfer_done;

    i2c_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .load    (gap_load),
        .enable  (state == GAP),
        .expired (gap_expired)
    );

    // xfer_start/xfer_data are registered out of ISSUE, so the pulse appears
    // on the first WAIT cycle: done -> start spacing is GAP_CYCLES+3
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            index      <= '0;
            retry      <= '0;
            xfer_start <= 1'b0;
            xfer_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            xfer_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        index <= '0;
                        retry <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: state <= ISSUE;
                ISSUE: begin
                    xfer_data  <= cfg_data;
                    xfer_start <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (xfer_done) begin
                        if (!xfer_nack) begin
                            retry <= '0;
                            if (index == LAST_IDX) begin
                                state <= FINISH;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                index <= index + 4'd1;
                                state <= GAP;
                            end
                        end else if (retry < RETRY_LIM) begin
                            retry <= retry + 3'd1;
                            state <= GAP;
                        end else begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_expired) state <= LOAD;
                end
                FINISH: state <= IDLE;
                FAIL:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench: ROM + I2C engine model, scoreboard of expected words,
// table of sequence scenarios plus hand-written reset/corner sequences.
import i2c_config_sequencer_pkg::*;

module tb_i2c_config_sequencer;

    localparam int NW = 3;
    localparam int GC = 4;
    localparam int MR = 3;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic              start;
    logic [3:0]        cfg_index;
    logic [WORD_W-1:0] cfg_data;
    logic              xfer_start;
    logic [WORD_W-1:0] xfer_data;
    logic              xfer_done;
    logic              xfer_nack;
    logic              busy, done, error;

    logic eng_done = 1'b0, eng_nack = 1'b0, man_done = 1'b0;
    assign xfer_done = eng_done | man_done;
    assign xfer_nack = eng_nack;

    i2c_config_sequencer #(
        .NUM_WORDS (NW), .GAP_CYCLES (GC), .MAX_RETRY (MR)
    ) dut (
        .CLOCK (CLOCK), .RESET (RESET), .start (start),
        .cfg_index (cfg_index), .cfg_data (cfg_data),
        .xfer_start (xfer_start), .xfer_data (xfer_data),
        .xfer_done (xfer_done), .xfer_nack (xfer_nack),
        .busy (busy), .done (done), .error (error)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ROM with one cycle of read latency
    logic [WORD_W-1:0] rom [16];
    initial for (int i = 0; i < 16; i++) rom[i] = {CODEC_ADDR, 1'b0, 16'hA000 + 16'(i * 16'h0111)};
    always @(posedge CLOCK) cfg_data <= rom[cfg_index];

    // engine model: answers each transfer 5 cycles after xfer_start
    logic [WORD_W-1:0] sb [$];
    int nack_idx = -1, nack_n = 0, hold_idx = -1;
    int att [16];
    int nstarts = 0, lat = 0, eng_idx = 0, last_done = 0;
    bit gap_valid = 0;

    always @(negedge CLOCK) begin
        eng_done = 1'b0;
        eng_nack = 1'b0;
        if (xfer_start) begin
            nstarts++;
            eng_idx = int'(cfg_index);
            att[eng_idx]++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got xfer_data %0h want no transfer", xfer_data);
            end else begin
                chk("xfer_data", 32'(xfer_data), 32'(sb.pop_front()));
            end
            if (gap_valid) begin
                chk("gap_cycles", 32'(cyc - last_done), 32'(GC + 3));
                gap_valid = 0;
            end
            lat = (eng_idx == hold_idx) ? 0 : 5;
        end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                eng_done  = 1'b1;
                eng_nack  = (eng_idx == nack_idx) && (att[eng_idx] <= nack_n);
                last_done = cyc;
                gap_valid = 1;
            end
        end
    end

    typedef struct {
        int mode;     // 0 plain, 1 start+done together in IDLE, 2 start+done during GAP
        int nidx;     // word to NACK (-1 none)
        int nn;       // how many leading attempts of that word are NACKed
        int starts;   // expected xfer_start count
        bit dn;
        bit er;
        int idx;      // expected final cfg_index
    } vec_t;

    vec_t tbl [7];

    task automatic setup(input int nidx, input int nn, input int hold);
        nack_idx  = nidx;
        nack_n    = nn;
        hold_idx  = hold;
        nstarts   = 0;
        gap_valid = 0;
        lat       = 0;
        foreach (att[i]) att[i] = 0;
        sb.delete();
        for (int i = 0; i < NW; i++) begin
            int a;
            a = (i == nidx) ? nn : 0;
            if (i == hold) begin
                sb.push_back(rom[i]);
                break;
            end
            if (a > MR) begin
                repeat (MR + 1) sb.push_back(rom[i]);
                break;
            end
            repeat (a + 1) sb.push_back(rom[i]);
        end
    endtask

    task automatic run_seq(input vec_t v);
        int n;
        setup(v.nidx, v.nn, -1);
        @(posedge CLOCK); #1;
        start = 1'b1;
        man_done = (v.mode == 1);
        @(posedge CLOCK); #1;
        start = 1'b0;
        man_done = 1'b0;
        if (v.mode == 2) begin
            n = 0;
            while (!eng_done && n < 200) begin
                @(posedge CLOCK); #1;
                n++;
            end
            if (n >= 200) chk("first_done_timeout", 32'(eng_done), 32'd1);
            start = 1'b1;
            man_done = 1'b1;
            @(posedge CLOCK); #1;
            start = 1'b0;
            man_done = 1'b0;
        end
        n = 0;
        while (busy && n < 500) begin
            @(posedge CLOCK); #1;
            n++;
        end
        if (n >= 500) chk("idle_timeout", 32'(busy), 32'd0);
        chk("starts",    32'(nstarts),   32'(v.starts));
        chk("done",      32'(done),      32'(v.dn));
        chk("error",     32'(error),     32'(v.er));
        chk("cfg_index", 32'(cfg_index), 32'(v.idx));
        chk("sb_left",   32'(sb.size()), 32'd0);
        repeat (20) @(posedge CLOCK);
        #1;
        chk("quiet_starts", 32'(nstarts), 32'(v.starts));
        chk("quiet_busy",   32'(busy),    32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cfg_index"},  32'(cfg_index),  32'd0);
        chk({tag, "_xfer_start"}, 32'(xfer_start), 32'd0);
        chk({tag, "_xfer_data"},  32'(xfer_data),  32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_error"},      32'(error),      32'd0);
    endtask

    initial begin
        int n;
        tbl[0] = '{0, -1,  0, 3, 1'b1, 1'b0, 2};
        tbl[1] = '{0,  1,  1, 4, 1'b1, 1'b0, 2};
        tbl[2] = '{0,  0, 99, 4, 1'b0, 1'b1, 0};
        tbl[3] = '{0,  2,  3, 6, 1'b1, 1'b0, 2};
        tbl[4] = '{0,  2,  4, 6, 1'b0, 1'b1, 2};
        tbl[5] = '{1, -1,  0, 3, 1'b1, 1'b0, 2};
        tbl[6] = '{2, -1,  0, 3, 1'b1, 1'b0, 2};

        RESET = 1'b1;
        start = 1'b1;   // reset must beat start
        repeat (3) @(posedge CLOCK);
        #1;
        chk_all_zero("reset");
        RESET = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 7; i++) run_seq(tbl[i]);

        // reset while waiting on word 1, then a late xfer_done
        setup(-1, 0, 1);
        @(posedge CLOCK); #1;
        start = 1'b1;
        @(posedge CLOCK); #1;
        start = 1'b0;
        n = 0;
        while (!(xfer_start && cfg_index == 4'd1) && n < 200) begin
            @(posedge CLOCK); #1;
            n++;
        end
        if (n >= 200) chk("wait1_timeout", 32'(cfg_index), 32'd1);
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        chk_all_zero("midwait_reset");
        @(posedge CLOCK); #1;
        man_done = 1'b1;
        @(posedge CLOCK); #1;
        man_done = 1'b0;
        repeat (20) @(posedge CLOCK);
        #1;
        chk("late_done_starts", 32'(nstarts),   32'd2);
        chk("late_done_busy",   32'(busy),      32'd0);
        chk("late_done_done",   32'(done),      32'd0);
        chk("late_done_sb",     32'(sb.size()), 32'd0);

        // block recovers cleanly after the abort
        run_seq(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
